intraloop_sched: RTL and testbench

Frame-level scheduler for the intra-prediction loop (intrapred → transformcoder → reconst). It walks macroblock numbers 0..frame_mbs-1 into the loop, drives the loop's `enable`, and tracks each in-flight macroblock with a token shift register matched to the loop depth. It presents completed macroblock numbers to a downstream sink with a valid/ready handshake, and freezes the whole loop under backpressure. It also signals frame completion.

---
 rtl/intraloop_sched_if.sv | 39 +++
 rtl/intraloop_sched.sv | 121 ++++++++++++
 tb/tb_intraloop_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/intraloop_sched_if.sv
// rtl/intraloop_sched_if.sv - handshake bundle between the frame scheduler and its environment
//
// Purpose: groups the frame control, loop drive and completed-MB handshake
// signals of intraloop_sched.
// Ports (signals):
//   start, abort, frame_mbs        frame control into the scheduler
//   loop_enable, loop_mbnumber     drive towards the intra loop
//   out_valid, out_mbnumber        completed MB at the loop tail
//   out_ready                      sink acceptance of the tail MB
//   busy, done, stall_cycles       frame status
// Modports: master = environment side, slave = scheduler side.
interface intraloop_sched_if #(
    parameter int MB_W    = 13,
    parameter int STALL_W = 16
) ();
    logic               start;
    logic               abort;
    logic [MB_W-1:0]    frame_mbs;
    logic               loop_enable;
    logic [MB_W-1:0]    loop_mbnumber;
    logic               out_valid;
    logic [MB_W-1:0]    out_mbnumber;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic [STALL_W-1:0] stall_cycles;

    modport master (
        output start, abort, frame_mbs, out_ready,
        input  loop_enable, loop_mbnumber, out_valid, out_mbnumber,
        input  busy, done, stall_cycles
    );

    modport slave (
        input  start, abort, frame_mbs, out_ready,
        output loop_enable, loop_mbnumber, out_valid, out_mbnumber,
        output busy, done, stall_cycles
    );
endinterface

// File: rtl/intraloop_sched.sv
// rtl/intraloop_sched.sv - frame-level scheduler for the intra-prediction loop
//
// Purpose: issues macroblock numbers 0..frame_mbs-1 into the intra loop,
// tracks each in-flight MB with a token pipe matched to the loop depth,
// hands completed MBs to a sink with valid/ready, freezes the loop under
// backpressure and pulses done at frame end.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   bus    intraloop_sched_if.slave (frame control, loop drive, output
//          handshake, status)
module intraloop_sched #(
    parameter int MB_W       = 13,
    parameter int PIPE_DEPTH = 11,
    parameter int STALL_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    intraloop_sched_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    logic [MB_W-1:0]      issue_cnt;
    logic [MB_W-1:0]      frame_len;
    logic [STALL_W-1:0]   stall_cnt;

    // Token pipe: index 0 is the entry stage, PIPE_DEPTH-1 is the loop tail.
    logic [PIPE_DEPTH-1:0] tok_vld;
    logic [MB_W-1:0]       tok_mb [PIPE_DEPTH];

    logic running;
    logic tail_vld;
    logic stall;
    logic enable;

    assign running  = (state == S_ISSUE) || (state == S_DRAIN);
    assign tail_vld = tok_vld[PIPE_DEPTH-1] && running;
    assign stall    = tail_vld && !bus.out_ready;
    // Whole loop freezes while the sink refuses the tail MB.
    assign enable   = running && !stall;

    assign bus.loop_enable   = enable;
    assign bus.loop_mbnumber = (state == S_ISSUE) ? issue_cnt : '0;
    assign bus.out_valid     = tail_vld;
    assign bus.out_mbnumber  = tok_mb[PIPE_DEPTH-1];
    assign bus.busy          = (state != S_IDLE);
    assign bus.done          = (state == S_DONE);
    assign bus.stall_cycles  = stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            frame_len <= '0;
            stall_cnt <= '0;
            tok_vld   <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                tok_mb[i] <= '0;
            end
        end else begin
            if (enable) begin
                // ISSUE injects a real MB; DRAIN injects a bubble.
                tok_vld   <= {tok_vld[PIPE_DEPTH-2:0], (state == S_ISSUE)};
                tok_mb[0] <= (state == S_ISSUE) ? issue_cnt : '0;
                for (int i = 1; i < PIPE_DEPTH; i++) begin
                    tok_mb[i] <= tok_mb[i-1];
                end
            end

            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end

            if (bus.abort) begin
                // Counter and stall count deliberately keep their values.
                state   <= S_IDLE;
                tok_vld <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            frame_len <= bus.frame_mbs;
                            issue_cnt <= '0;
                            stall_cnt <= '0;
                            state     <= (bus.frame_mbs == '0) ? S_DONE : S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (enable) begin
                            issue_cnt <= issue_cnt + MB_W'(1);
                            if (issue_cnt == frame_len - MB_W'(1)) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // An enabled cycle already implies the tail is empty
                        // or being accepted, so only the upstream stages matter.
                        if (enable && (tok_vld[PIPE_DEPTH-2:0] == '0)) begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_intraloop_sched.sv
// tb/tb_intraloop_sched.sv - self-checking bench for intraloop_sched
module tb_intraloop_sched;

    localparam int MB_W    = 13;
    localparam int D       = 11;
    localparam int STALL_W = 16;

    logic clk;
    logic reset;
    int   checks;
    int   passed;

    intraloop_sched_if #(.MB_W(MB_W), .STALL_W(STALL_W)) bus ();

    intraloop_sched #(.MB_W(MB_W), .PIPE_DEPTH(D), .STALL_W(STALL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle 0 of a frame: start is presented before the next rising edge.
    task automatic begin_frame(input int n);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        bus.frame_mbs = MB_W'(n);
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.frame_mbs = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.loop_enable, bus.out_valid, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000",
                     {bus.loop_enable, bus.out_valid, bus.busy, bus.done});
        else passed++;
        checks++;
        if (bus.loop_mbnumber !== '0 || bus.out_mbnumber !== '0 || bus.stall_cycles !== '0)
            $display("FAIL reset_values got loop_mb=%0d out_mb=%0d stall=%0d want 0",
                     bus.loop_mbnumber, bus.out_mbnumber, bus.stall_cycles);
        else passed++;
    endtask

    // N=4, sink always ready: outputs follow the nominal timeline exactly.
    task automatic test_basic;
        int n;
        n = 4;
        begin_frame(n);
        for (int c = 1; c <= n + D + 3; c++) begin
            logic exp_busy, exp_done, exp_val, exp_en;
            int   exp_lmb;
            @(posedge clk); #1;
            bus.start = 1'b0;
            #1;
            exp_busy = (c <= n + D + 1);
            exp_done = (c == n + D + 1);
            exp_val  = (c >= 1 + D) && (c <= n + D);
            exp_en   = (c <= n + D);
            exp_lmb  = (c <= n) ? c - 1 : 0;
            checks++;
            if ({bus.busy, bus.done, bus.out_valid, bus.loop_enable} !==
                {exp_busy, exp_done, exp_val, exp_en})
                $display("FAIL basic_flags c%0d got busy/done/val/en=%b want %b", c,
                         {bus.busy, bus.done, bus.out_valid, bus.loop_enable},
                         {exp_busy, exp_done, exp_val, exp_en});
            else passed++;
            checks++;
            if (bus.loop_mbnumber !== MB_W'(exp_lmb))
                $display("FAIL basic_loop_mb c%0d got %0d want %0d", c, bus.loop_mbnumber, exp_lmb);
            else passed++;
            if (exp_val) begin
                checks++;
                if (bus.out_mbnumber !== MB_W'(c - 1 - D))
                    $display("FAIL basic_out_mb c%0d got %0d want %0d", c, bus.out_mbnumber, c - 1 - D);
                else passed++;
            end
        end
        checks++;
        if (bus.stall_cycles !== '0)
            $display("FAIL basic_stall got %0d want 0", bus.stall_cycles);
        else passed++;
    endtask

    // N=4, sink refuses in cycles 12..14: every later event shifts by 3.
    task automatic test_stall;
        int n;
        int exp_mb;
        n = 4;
        begin_frame(n);
        for (int c = 1; c <= 21; c++) begin
            logic exp_val, exp_en, exp_done, exp_busy;
            @(posedge clk); #1;
            bus.start     = 1'b0;
            bus.out_ready = !(c >= 12 && c <= 14);
            #1;
            exp_val  = (c >= 12) && (c <= 18);
            exp_en   = (c <= 11) || (c >= 15 && c <= 18);
            exp_done = (c == 19);
            exp_busy = (c <= 19);
            exp_mb   = (c <= 15) ? 0 : c - 15;
            checks++;
            if ({bus.out_valid, bus.loop_enable, bus.done, bus.busy} !==
                {exp_val, exp_en, exp_done, exp_busy})
                $display("FAIL stall_flags c%0d got val/en/done/busy=%b want %b", c,
                         {bus.out_valid, bus.loop_enable, bus.done, bus.busy},
                         {exp_val, exp_en, exp_done, exp_busy});
            else passed++;
            if (exp_val) begin
                checks++;
                if (bus.out_mbnumber !== MB_W'(exp_mb))
                    $display("FAIL stall_out_mb c%0d got %0d want %0d", c, bus.out_mbnumber, exp_mb);
                else passed++;
            end
        end
        bus.out_ready = 1'b1;
        checks++;
        if (bus.stall_cycles !== STALL_W'(3))
            $display("FAIL stall_count got %0d want 3", bus.stall_cycles);
        else passed++;
    endtask

    task automatic test_zero;
        begin_frame(0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            #1;
            checks++;
            if ({bus.done, bus.busy, bus.loop_enable, bus.out_valid} !==
                {(c == 1), (c == 1), 1'b0, 1'b0})
                $display("FAIL zero_frame c%0d got done/busy/en/val=%b want %b", c,
                         {bus.done, bus.busy, bus.loop_enable, bus.out_valid},
                         {(c == 1), (c == 1), 2'b00});
            else passed++;
        end
    endtask

    // Abort in cycle 6; a start in cycle 3 (while busy, with a different
    // frame size) must have no effect on the running issue sequence.
    task automatic test_abort;
        begin_frame(20);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            bus.start     = (c == 3);
            bus.frame_mbs = (c == 3) ? MB_W'(2) : MB_W'(20);
            bus.abort     = (c == 6);
            #1;
            if (c <= 6) begin
                checks++;
                if (!bus.busy || !bus.loop_enable || bus.loop_mbnumber !== MB_W'(c - 1))
                    $display("FAIL abort_pre c%0d got busy=%b en=%b mb=%0d want 1 1 %0d",
                             c, bus.busy, bus.loop_enable, bus.loop_mbnumber, c - 1);
                else passed++;
            end else begin
                checks++;
                if ({bus.busy, bus.loop_enable, bus.out_valid, bus.done} !== 4'b0000)
                    $display("FAIL abort_post c%0d got busy/en/val/done=%b want 0000", c,
                             {bus.busy, bus.loop_enable, bus.out_valid, bus.done});
                else passed++;
            end
        end
        bus.abort = 1'b0;
    endtask

    // Generic frame with randomized sink readiness, checked against the
    // timing rule: done at N+D+1 plus one cycle per stall.
    task automatic test_random_frame(input string tag, input int n, input int ready_pct);
        int next_mb, stalls, dones, done_c, c, limit;
        bit finished;
        next_mb = 0; stalls = 0; dones = 0; done_c = -1; finished = 0;
        limit = 4 * n + D + 50;
        begin_frame(n);
        for (c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            bus.start     = 1'b0;
            bus.out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (bus.out_valid && !bus.out_ready) stalls++;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_mbnumber !== MB_W'(next_mb))
                    $display("FAIL %s_order c%0d got %0d want %0d", tag, c, bus.out_mbnumber, next_mb);
                else passed++;
                next_mb++;
            end
            if (bus.done) begin
                dones++;
                done_c = c;
            end
            if (!bus.busy) begin
                finished = 1;
                break;
            end
        end
        bus.out_ready = 1'b1;
        checks++;
        if (!finished)
            $display("FAIL %s_timeout got busy after %0d cycles want idle", tag, limit);
        else passed++;
        checks++;
        if (next_mb != n)
            $display("FAIL %s_count got %0d MBs want %0d", tag, next_mb, n);
        else passed++;
        checks++;
        if (dones != 1 || done_c != n + D + 1 + stalls)
            $display("FAIL %s_done got %0d pulses at c%0d want 1 at c%0d", tag, dones, done_c,
                     n + D + 1 + stalls);
        else passed++;
        checks++;
        if (bus.stall_cycles !== STALL_W'((stalls > 65535) ? 65535 : stalls))
            $display("FAIL %s_stall got %0d want %0d", tag, bus.stall_cycles, stalls);
        else passed++;
    endtask

    task automatic test_reset_mid;
        begin_frame(20);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        #1;
        checks++;
        if (!bus.loop_enable || bus.loop_mbnumber !== MB_W'(4))
            $display("FAIL rstmid_pre got en=%b mb=%0d want 1 4", bus.loop_enable, bus.loop_mbnumber);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.loop_enable, bus.out_valid, bus.busy, bus.done} !== 4'b0000 ||
            bus.loop_mbnumber !== '0 || bus.out_mbnumber !== '0 || bus.stall_cycles !== '0)
            $display("FAIL rstmid_clear got en/val/busy/done=%b lmb=%0d omb=%0d want all 0",
                     {bus.loop_enable, bus.out_valid, bus.busy, bus.done},
                     bus.loop_mbnumber, bus.out_mbnumber);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #2;
            checks++;
            if (bus.done || bus.busy)
                $display("FAIL rstmid_quiet c%0d got done=%b busy=%b want 0 0", c, bus.done, bus.busy);
            else passed++;
        end
        test_random_frame("rstmid_frame", 3, 100);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_abort();
        test_reset_mid();
        test_random_frame("rand_small", 37, 70);
        test_random_frame("rand_max", 8191, 60);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
